// File: rtl/bcd_pkg.sv
// Shared types, constants and the width helper for the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest legal decimal digit.
    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    // A nibble at or above this value after a right shift needs correcting.
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    // Correction subtracted from such a nibble.
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    // Smallest binary width w with 2^w >= 10^digits.
    function automatic int bcd_min_bin_w(input int digits);
        longint unsigned lim;
        int              w;
        lim = 64'd1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 64'd10;
        end
        w = 0;
        for (int b = 0; b < 63; b++) begin
            if ((64'd1 << b) < lim) begin
                w = b + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_rdd_adj.sv
// One nibble of the reverse double-dabble correction: subtract 3 when >= 8.
module bcd_rdd_adj
    import bcd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] adj
);

    assign adj = (nibble >= BCD_ADJ_THRESH) ? (nibble - BCD_ADJ) : nibble;

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter (reverse double dabble).
// A request latches bcd_in, checks every digit, then runs BIN_W shift/adjust
// steps and publishes the result with a one-cycle valid pulse.
// Optional build macro BCD_TO_BIN_KEY_SYNC_EN: start becomes a raw active-low
// pushbutton with a 2-flop synchronizer and a registered falling-edge detector.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  valid,
    output logic                  busy,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    // Refuse to build a converter whose result could wrap.
    if (BIN_W < bcd_min_bin_w(DIGITS)) begin : g_width_check
        $error("bcd_to_bin: BIN_W too small for DIGITS");
    end

    state_t              state;
    state_t              next_state;
    logic [BCD_W-1:0]    bcd_w;
    logic [BIN_W-1:0]    bin_w;
    logic [CNT_W-1:0]    cnt;
    logic                err_pend;
    logic                req;
    logic                accept;
    logic                digit_bad;
    logic [WORK_W-1:0]   shifted;
    logic [BCD_W-1:0]    bcd_adj;

`ifdef BCD_TO_BIN_KEY_SYNC_EN
    logic key_s1;
    logic key_s2;
    logic key_prev;

    // Synchronize the pushbutton and emit one request per press (falling edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_prev <= 1'b1;
            req      <= 1'b0;
        end else begin
            key_s1   <= start;
            key_s2   <= key_s1;
            key_prev <= key_s2;
            req      <= key_prev & ~key_s2;
        end
    end
`else
    assign req = start;
`endif

    // A request is taken only when idle and not in the cycle the result is published.
    assign accept = (state == IDLE) && req && !valid;

    // Flag any latched digit above 9.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_w[4*i +: 4] > BCD_DIGIT_MAX) begin
                digit_bad = 1'b1;
            end
        end
    end

    assign shifted = {bcd_w, bin_w} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_rdd_adj u_adj (
            .nibble (shifted[BIN_W + 4*g +: 4]),
            .adj    (bcd_adj[4*g +: 4])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CHECK;
            CHECK:   next_state = digit_bad ? DONE : SHIFT;
            SHIFT:   if (cnt == CNT_LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Work register, iteration counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the work register and counter are reset as well, so an aborted
            // conversion leaves no stale data behind.
            bcd_w    <= '0;
            bin_w    <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            bin_out  <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= 1'b0;
            busy  <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        bcd_w <= bcd_in;
                        bin_w <= '0;
                    end
                end
                CHECK: begin
                    cnt      <= '0;
                    err_pend <= digit_bad;
                end
                SHIFT: begin
                    bcd_w <= bcd_adj;
                    bin_w <= shifted[BIN_W-1:0];
                    cnt   <= cnt + CNT_W'(1);
                end
                DONE: begin
                    valid   <= 1'b1;
                    bin_out <= err_pend ? '0 : bin_w;
                    err     <= err_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed-vector bench for bcd_to_bin (default DIGITS=2, BIN_W=7).
module tb_bcd_to_bin;

`ifdef BCD_TO_BIN_KEY_SYNC_EN
    localparam logic START_ACT = 1'b0;
    localparam int   ACC_DLY   = 3;
`else
    localparam logic START_ACT = 1'b1;
    localparam int   ACC_DLY   = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] bcd_in;
    logic [6:0] bin_out;
    logic       valid;
    logic       busy;
    logic       err;

    int checks;
    int errors;

    bcd_to_bin #(.DIGITS(2), .BIN_W(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .valid   (valid),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request; returns at the falling edge just after the accepting edge.
    task automatic pulse_start(input logic [7:0] v);
        @(negedge clk);
        bcd_in = v;
        start  = START_ACT;
        @(negedge clk);
        start  = ~START_ACT;
        repeat (ACC_DLY) @(negedge clk);
    endtask

    // Wait up to limit cycles for valid; lat = cycle index or -1.
    task automatic wait_valid(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = ~START_ACT;
        bcd_in = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (bin_out !== 7'd0) begin errors++; $display("FAIL reset_bin_out: got %0d expected 0", bin_out); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_max_value();
        logic exp_v;
        logic exp_b;
        pulse_start(8'h99);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_v = (k == 9);
            exp_b = (k >= 1) && (k <= 9);
            checks++; if (valid !== exp_v) begin errors++; $display("FAIL max_valid k=%0d: got %b expected %b", k, valid, exp_v); end
            checks++; if (busy !== exp_b)  begin errors++; $display("FAIL max_busy k=%0d: got %b expected %b", k, busy, exp_b); end
            if (k == 9) begin
                checks++; if (bin_out !== 7'd99) begin errors++; $display("FAIL max_bin_out: got %0d expected 99", bin_out); end
                checks++; if (err !== 1'b0)      begin errors++; $display("FAIL max_err: got %b expected 0", err); end
            end
        end
    endtask

    task automatic test_sequence();
        logic [7:0] vec [3];
        logic [6:0] exp [3];
        int lat;
        vec = '{8'h00, 8'h47, 8'h10};
        exp = '{7'd0, 7'd47, 7'd10};
        for (int i = 0; i < 3; i++) begin
            pulse_start(vec[i]);
            wait_valid(20, lat);
            checks++; if (lat != 9) begin errors++; $display("FAIL seq_latency %0d: got %0d expected 9", i, lat); end
            checks++; if (bin_out !== exp[i]) begin errors++; $display("FAIL seq_bin_out %0d: got %0d expected %0d", i, bin_out, exp[i]); end
            @(negedge clk);
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL seq_valid_width %0d: got %b expected 0", i, valid); end
            repeat (3) begin
                @(negedge clk);
                checks++; if (bin_out !== exp[i]) begin errors++; $display("FAIL seq_hold %0d: got %0d expected %0d", i, bin_out, exp[i]); end
            end
        end
    endtask

    task automatic test_bad_digit();
        int lat;
        pulse_start(8'h4A);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (valid !== (k == 2)) begin errors++; $display("FAIL bad_valid k=%0d: got %b expected %b", k, valid, (k == 2)); end
            if (k == 2) begin
                checks++; if (err !== 1'b1)      begin errors++; $display("FAIL bad_err: got %b expected 1", err); end
                checks++; if (bin_out !== 7'd0)  begin errors++; $display("FAIL bad_bin_out: got %0d expected 0", bin_out); end
            end
        end
        pulse_start(8'h42);
        wait_valid(20, lat);
        checks++; if (lat != 9)          begin errors++; $display("FAIL good_after_bad_latency: got %0d expected 9", lat); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL good_after_bad_err: got %b expected 0", err); end
        checks++; if (bin_out !== 7'd42) begin errors++; $display("FAIL good_after_bad_bin_out: got %0d expected 42", bin_out); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int         nvalid;
        int         vk;
        logic [6:0] vbin;
        nvalid = 0;
        vk     = -1;
        vbin   = '0;
        pulse_start(8'h25);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (valid) begin
                nvalid++;
                vk   = k;
                vbin = bin_out;
            end
            if (k == 3 || k == 9) start = START_ACT;
            if (k == 4) begin
                start  = ~START_ACT;
                bcd_in = 8'h77;
            end
            if (k == 10) start = ~START_ACT;
        end
        checks++; if (nvalid != 1)     begin errors++; $display("FAIL ignore_valid_count: got %0d expected 1", nvalid); end
        checks++; if (vk != 9)         begin errors++; $display("FAIL ignore_latency: got %0d expected 9", vk); end
        checks++; if (vbin !== 7'd25)  begin errors++; $display("FAIL ignore_bin_out: got %0d expected 25", vbin); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL ignore_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int nvalid;
        pulse_start(8'hF0);
        wait_valid(10, lat);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_pre_err: got %b expected 1", err); end
        pulse_start(8'h63);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bin_out !== 7'd0) begin errors++; $display("FAIL abort_bin_out: got %0d expected 0", bin_out); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL abort_err: got %b expected 0", err); end
        nvalid = 0;
        repeat (2) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        checks++; if (nvalid != 0) begin errors++; $display("FAIL abort_no_valid: got %0d expected 0", nvalid); end
        pulse_start(8'h63);
        wait_valid(20, lat);
        checks++; if (lat != 9)          begin errors++; $display("FAIL abort_restart_latency: got %0d expected 9", lat); end
        checks++; if (bin_out !== 7'd63) begin errors++; $display("FAIL abort_restart_bin_out: got %0d expected 63", bin_out); end
        repeat (2) @(negedge clk);
    endtask

`ifdef BCD_TO_BIN_KEY_SYNC_EN
    task automatic test_key_sync();
        int nvalid;
        int lat;
        nvalid = 0;
        @(negedge clk);
        bcd_in = 8'h12;
        start  = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        start = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        checks++; if (nvalid != 1)       begin errors++; $display("FAIL key_hold_count: got %0d expected 1", nvalid); end
        checks++; if (bin_out !== 7'd12) begin errors++; $display("FAIL key_hold_bin_out: got %0d expected 12", bin_out); end
        pulse_start(8'h34);
        wait_valid(20, lat);
        checks++; if (lat != 9)          begin errors++; $display("FAIL key_repress_latency: got %0d expected 9", lat); end
        checks++; if (bin_out !== 7'd34) begin errors++; $display("FAIL key_repress_bin_out: got %0d expected 34", bin_out); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_max_value();
        test_sequence();
        test_bad_digit();
`ifndef BCD_TO_BIN_KEY_SYNC_EN
        test_ignore_start();
`endif
        test_reset_abort();
`ifdef BCD_TO_BIN_KEY_SYNC_EN
        test_key_sync();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Iterative BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from each nibble that is >= 8.
- Inverse of the board's binary-to-BCD path: the user enters decimal digits on SW[7:0] (tens in [7:4], ones in [3:0]), triggers with a key, and reads the binary result on LEDR.
- Multi-cycle FSM with start/busy/valid handshake and invalid-digit detection.

Parameters:
- DIGITS, 2, number of BCD input digits.
- BIN_W, 7, binary result width. Must satisfy 2^BIN_W >= 10^DIGITS; the block raises an elaboration error otherwise.

Ports:
- clk  input  1  system clock (CLOCK_50 at top).
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; format depends on KEY_SYNC_EN.
- bcd_in  input  4*DIGITS  packed BCD digits, most significant digit in the top nibble.
- bin_out  output  BIN_W  last conversion result, registered.
- valid  output  1  one-cycle pulse when bin_out/err update.
- busy  output  1  high from the cycle after start is accepted until the cycle after valid.
- err  output  1  last request contained a digit > 9; registered.

Behaviour:
- States: IDLE, CHECK, SHIFT, DONE. Reset (async, rst_n=0) forces IDLE and sets bin_out=0, valid=0, busy=0, err=0, iteration counter=0, work register=0.
- IDLE: a start seen at clock edge N latches bcd_in into the BCD half of the work register {bcd_w, bin_w}, clears bin_w, then moves to CHECK. busy=1 from N+1.
- CHECK (1 cycle):
  - If any nibble > 9, go to DONE with err_next=1.
  - Otherwise go to SHIFT with counter=0 and err_next=0.
- SHIFT (exactly BIN_W cycles):
  - Each cycle: shift {bcd_w, bin_w} right by one, then for each nibble of the shifted bcd_w, if nibble >= 8 subtract 3.
  - counter increments; after BIN_W cycles, go to DONE.
- DONE (1 cycle):
  - valid=1.
  - bin_out = bin_w, or 0 if err_next; err = err_next.
  - Next state IDLE; busy drops the following cycle.
- Latency from the start edge to the valid-high cycle:
  - Good digits: BIN_W+2 cycles (9 at defaults).
  - Bad digit: 2 cycles.
- bin_out and err hold between conversions. They change only in DONE or on reset.
- start while busy (CHECK, SHIFT or DONE) is ignored and not queued. start in the same cycle valid is high is also ignored.
- Changes on bcd_in after acceptance have no effect on the running conversion.
- Reset asserted mid-conversion aborts immediately: no valid pulse, outputs return to reset values.
- Arithmetic: results are exact for all legal inputs 0 .. 10^DIGITS-1; no wrap-around is possible given the BIN_W constraint.

Optional Feature:
- Macro: BCD_TO_BIN_KEY_SYNC_EN.
- Defined: start is a raw, asynchronous, active-low pushbutton (KEY1).
  - The block contains a 2-flop synchronizer plus a registered falling-edge detector.
  - Acceptance occurs 3 clocks after the synchronized press edge.
  - Holding the key produces exactly one request.
  - Synchronizer flops reset to 1 (button released).
- Undefined: start is an active-high, already-synchronous signal. Each cycle it is high in IDLE is a request, with no internal edge detection.

Decomposition:
- Package bcd_pkg contains:
  - state encoding type (IDLE/CHECK/SHIFT/DONE);
  - constants BCD_DIGIT_MAX=9, BCD_ADJ_THRESH=8, BCD_ADJ=3;
  - function bcd_min_bin_w(digits) for the width check.
- Sub-module bcd_rdd_adj: a combinational 4-bit cell (nibble >= 8 ? nibble-3 : nibble), instantiated DIGITS times by generate. Top-level FSM, counter and registers stay in bcd_to_bin.

Test Plan:
- bcd_in=8'h99, start pulse → valid exactly 9 cycles later, bin_out=7'd99, err=0; busy high for cycles 1..9 after start.
- bcd_in=8'h00, then 8'h47, then 8'h10 → bin_out 0, 47, 10 in turn; each valid is a single cycle; bin_out is stable between runs.
- bcd_in=8'h4A, start → valid 2 cycles later, err=1, bin_out=0; next request with 8'h42 → err=0, bin_out=42.
- Start 8'h25, pulse start again at cycles +3 and +9, and change bcd_in to 8'h77 at +4 → one valid only, bin_out=25.
- Start 8'h63, drop rst_n at cycle +5 for 2 cycles → no valid; bin_out=0, busy=0, err=0; fresh start on 8'h63 gives 63.
- With BCD_TO_BIN_KEY_SYNC_EN, start held low for 50 cycles on 8'h12 → exactly one conversion; bin_out=12; release and re-press → second conversion.
